// File: rtl/vga_fetch_sched.sv
`timescale 1ns/1ps
// Pixel-domain frame-buffer read scheduler. Issues credit-limited burst reads that keep the
// display FIFO supplied, and raises sticky underflow/overrun flags for software.
module vga_fetch_sched #(
    parameter int unsigned HDISP      = 800,
    parameter int unsigned VDISP      = 480,
    parameter int unsigned BURST      = 16,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned AW         = 32
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst_n,
    input  logic          enable,
    input  logic          frame_sync,
    input  logic [AW-1:0] frame_base,
    output logic          req_valid,
    input  logic          req_ready,
    output logic [AW-1:0] req_addr,
    output logic [7:0]    req_len,
    input  logic          fifo_wr,
    input  logic          fifo_rd,
    output logic          frame_done,
    output logic          underflow,
    output logic          overrun
);
    localparam int unsigned NBURSTS = HDISP * VDISP / BURST;
    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BW      = $clog2(NBURSTS + 1);

    localparam logic [CW-1:0] BURST_C   = CW'(BURST);
    localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] NBURSTS_C = BW'(NBURSTS);
    localparam logic [AW-1:0] STRIDE    = AW'(BURST * 4);

    typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

    state_e        state_q, state_d;
    logic          req_valid_q, req_valid_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic [AW-1:0] base_q, base_d;
    logic [BW-1:0] left_q, left_d;
    logic [CW-1:0] committed_q, committed_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic          reload_pend_q, reload_pend_d;
    logic          frame_done_q, frame_done_d;
    logic          underflow_q, underflow_d;
    logic          overrun_q, overrun_d;
    logic          hs, pending, rd_ok, reload, credit_ok;

    assign hs      = req_valid_q && req_ready;
    assign pending = req_valid_q && !req_ready;
    assign rd_ok   = fifo_rd && (fifo_cnt_q != '0);

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        base_d        = base_q;
        left_d        = left_q;
        reload_pend_d = reload_pend_q;
        frame_done_d  = 1'b0;
        reload        = 1'b0;
        underflow_d   = underflow_q | (fifo_rd && (fifo_cnt_q == '0));
        overrun_d     = overrun_q | (frame_sync && (state_q == StFetch));

        fifo_cnt_d = fifo_cnt_q;
        if (fifo_wr && !rd_ok) begin
            fifo_cnt_d = fifo_cnt_q + CW'(1);
        end else if (!fifo_wr && rd_ok) begin
            fifo_cnt_d = fifo_cnt_q - CW'(1);
        end

        // Floor at zero: a read can only outnumber credits after software misaligns the FIFO.
        committed_d = committed_q;
        if (hs) committed_d = committed_d + BURST_C;
        if (rd_ok && (committed_d != '0)) committed_d = committed_d - CW'(1);

        if (frame_sync) base_d = frame_base;

        if (hs) begin
            req_addr_d = req_addr_q + STRIDE;
            left_d     = left_q - BW'(1);
            if (left_q == BW'(1)) begin
                frame_done_d = 1'b1;
                state_d      = StDone;
            end
        end

        unique case (state_q)
            StIdle, StDone: reload = frame_sync && enable;
            StFetch: begin
                if (frame_sync && enable && pending) begin
                    reload_pend_d = 1'b1;
                end else if ((frame_sync && enable) || (reload_pend_q && hs)) begin
                    reload = 1'b1;
                end
            end
            default: ;
        endcase

        if (reload) begin
            state_d       = StFetch;
            req_addr_d    = frame_sync ? frame_base : base_q;
            left_d        = NBURSTS_C;
            reload_pend_d = 1'b0;
        end

        if (!enable && !pending) begin
            state_d       = StIdle;
            reload_pend_d = 1'b0;
        end

        credit_ok = ({1'b0, committed_d} + {1'b0, BURST_C}) <= DEPTH_C;
        if (pending) begin
            req_valid_d = 1'b1;
        end else begin
            req_valid_d = (state_d == StFetch) && (left_d != '0) && credit_ok;
        end
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state_q       <= StIdle;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            base_q        <= '0;
            left_q        <= '0;
            committed_q   <= '0;
            fifo_cnt_q    <= '0;
            reload_pend_q <= 1'b0;
            frame_done_q  <= 1'b0;
            underflow_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            base_q        <= base_d;
            left_q        <= left_d;
            committed_q   <= committed_d;
            fifo_cnt_q    <= fifo_cnt_d;
            reload_pend_q <= reload_pend_d;
            frame_done_q  <= frame_done_d;
            underflow_q   <= underflow_d;
            overrun_q     <= overrun_d;
        end
    end

    assign req_valid  = req_valid_q;
    assign req_addr   = req_addr_q;
    assign req_len    = 8'(BURST);
    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_vga_fetch_sched.sv
`timescale 1ns/1ps
// Bench for vga_fetch_sched: vector table, directed corner sequences and randomized frames
// checked against a credit/address reference model. A reduced frame keeps run time short.
module tb_vga_fetch_sched;
    localparam int unsigned HDISP      = 64;
    localparam int unsigned VDISP      = 32;
    localparam int unsigned BURST      = 16;
    localparam int unsigned FIFO_DEPTH = 256;
    localparam int unsigned AW         = 32;
    localparam int unsigned NB         = HDISP * VDISP / BURST;

    logic          pixel_clk   = 1'b0;
    logic          pixel_rst_n = 1'b0;
    logic          enable      = 1'b0;
    logic          frame_sync  = 1'b0;
    logic [AW-1:0] frame_base  = '0;
    logic          req_ready   = 1'b0;
    logic          fifo_wr     = 1'b0;
    logic          fifo_rd     = 1'b0;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_len;
    logic          frame_done;
    logic          underflow;
    logic          overrun;

    int n_tests = 0;
    int n_fail  = 0;

    vga_fetch_sched #(
        .HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .FIFO_DEPTH(FIFO_DEPTH), .AW(AW)
    ) dut (
        .pixel_clk  (pixel_clk),
        .pixel_rst_n(pixel_rst_n),
        .enable     (enable),
        .frame_sync (frame_sync),
        .frame_base (frame_base),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .fifo_wr    (fifo_wr),
        .fifo_rd    (fifo_rd),
        .frame_done (frame_done),
        .underflow  (underflow),
        .overrun    (overrun)
    );

    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic do_reset();
        pixel_rst_n = 1'b0;
        enable = 1'b0; frame_sync = 1'b0; frame_base = '0;
        req_ready = 1'b0; fifo_wr = 1'b0; fifo_rd = 1'b0;
        repeat (2) tick();
        pixel_rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        int unsigned exp_cnt;
        logic        exp_uf;
    } vec_t;

    vec_t vecs [8];

    // Reference model state for randomized frames
    int unsigned   m_committed, m_fifo, m_left, m_issued, outstanding, n_done, cyc, n_hs;
    logic          m_valid, hs, rd_ok, exp_done, bad;
    logic [AW-1:0] base, exp_addr, last_addr;
    int            start_fail;

    initial begin
        vecs[0] = '{wr: 1'b0, rd: 1'b0, exp_cnt: 0, exp_uf: 1'b0};
        vecs[1] = '{wr: 1'b1, rd: 1'b1, exp_cnt: 1, exp_uf: 1'b1};
        vecs[2] = '{wr: 1'b1, rd: 1'b0, exp_cnt: 2, exp_uf: 1'b1};
        vecs[3] = '{wr: 1'b1, rd: 1'b1, exp_cnt: 2, exp_uf: 1'b1};
        vecs[4] = '{wr: 1'b0, rd: 1'b1, exp_cnt: 1, exp_uf: 1'b1};
        vecs[5] = '{wr: 1'b0, rd: 1'b1, exp_cnt: 0, exp_uf: 1'b1};
        vecs[6] = '{wr: 1'b0, rd: 1'b1, exp_cnt: 0, exp_uf: 1'b1};
        vecs[7] = '{wr: 1'b0, rd: 1'b0, exp_cnt: 0, exp_uf: 1'b1};

        // Reset values, observed while reset is held
        pixel_rst_n = 1'b0;
        repeat (2) tick();
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_addr", req_addr, 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_req_len", 32'(req_len), 32'd16);
        check("rst_committed", 32'(dut.committed_q), 32'd0);

        // Counter/underflow vectors in IDLE (no frame_sync, so no requests)
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fifo_wr = vecs[i].wr;
            fifo_rd = vecs[i].rd;
            tick();
            check($sformatf("vec%0d_fifo_cnt", i), 32'(dut.fifo_cnt_q), vecs[i].exp_cnt);
            check($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].exp_uf));
            check($sformatf("vec%0d_req_valid", i), 32'(req_valid), 32'd0);
            if (i == 1) check("empty_read_committed", 32'(dut.committed_q), 32'd0);
        end
        fifo_wr = 1'b0; fifo_rd = 1'b0;

        // Steady frame: 16 bursts fill all credit, then stall
        do_reset();
        enable = 1'b1; frame_base = 32'h1000; req_ready = 1'b1; frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0; frame_base = '0;
        check("valid_after_sync", 32'(req_valid), 32'd1);
        n_hs = 0;
        for (int c = 0; c < 40; c++) begin
            if (req_valid) begin
                check($sformatf("steady_addr%0d", n_hs), req_addr, 32'h1000 + 32'(64 * n_hs));
                n_hs++;
            end
            tick();
        end
        check("steady_bursts", n_hs, 32'd16);
        check("steady_committed", 32'(dut.committed_q), 32'd256);
        check("steady_stall", 32'(req_valid), 32'd0);

        // Credit release: 16 words arrive, 16 reads free exactly one burst of credit
        fifo_wr = 1'b1;
        repeat (16) tick();
        fifo_wr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fifo_rd = 1'b1;
            tick();
            if (i == 14) check("no_req_after_15_reads", 32'(req_valid), 32'd0);
        end
        fifo_rd = 1'b0;
        check("req_after_16_reads", 32'(req_valid), 32'd1);
        check("release_addr", req_addr, 32'h1400);
        tick();
        check("release_committed", 32'(dut.committed_q), 32'd256);
        check("release_stall", 32'(req_valid), 32'd0);

        // Randomized full frames against the reference model; second frame wraps the address
        do_reset();
        enable = 1'b1;
        m_committed = 0; m_fifo = 0; outstanding = 0; m_valid = 1'b0; m_left = 0;
        for (int f = 0; f < 2; f++) begin
            base = (f == 0) ? ($urandom() & 32'h0FFF_FFFC) : 32'hFFFF_F000;
            frame_base = base; frame_sync = 1'b1;
            m_left = NB; m_issued = 0; n_done = 0; cyc = 0; last_addr = '0;
            start_fail = n_fail;
            while (!(m_issued == NB && outstanding == 0 && m_fifo == 0) && cyc < 20000 &&
                   n_fail == start_fail) begin
                req_ready = ($urandom_range(0, 3) != 0);
                fifo_wr   = (outstanding > 0) && ($urandom_range(0, 3) != 0);
                fifo_rd   = (m_fifo > 0) && ($urandom_range(0, 7) != 0);
                hs    = m_valid && req_ready;
                rd_ok = fifo_rd && (m_fifo > 0);
                if (hs) begin
                    exp_addr = base + 32'(64 * m_issued);
                    check("rand_req_addr", req_addr, exp_addr);
                    last_addr = req_addr;
                end
                exp_done = hs && (m_left == 1);
                if (hs) begin
                    m_committed += BURST;
                    outstanding += BURST;
                    m_left--;
                    m_issued++;
                end
                if (rd_ok) m_committed--;
                if (fifo_wr) outstanding--;
                m_fifo = m_fifo + 32'(fifo_wr) - 32'(rd_ok);
                m_valid = (m_valid && !req_ready) ||
                          (m_left > 0 && m_committed + BURST <= FIFO_DEPTH);
                tick();
                frame_sync = 1'b0;
                check("rand_req_valid", 32'(req_valid), 32'(m_valid));
                check("rand_frame_done", 32'(frame_done), 32'(exp_done));
                check("rand_committed", 32'(dut.committed_q), m_committed);
                if (frame_done) n_done++;
                cyc++;
            end
            req_ready = 1'b0; fifo_wr = 1'b0; fifo_rd = 1'b0; frame_sync = 1'b0;
            check($sformatf("frame%0d_requests", f), m_issued, NB);
            check($sformatf("frame%0d_last_addr", f), last_addr, base + 32'(64 * (NB - 1)));
            check($sformatf("frame%0d_done_pulses", f), n_done, 32'd1);
            check($sformatf("frame%0d_underflow", f), 32'(underflow), 32'd0);
            check($sformatf("frame%0d_overrun", f), 32'(overrun), 32'd0);
            check($sformatf("frame%0d_idle_after", f), 32'(req_valid), 32'd0);
        end

        // Backpressure, then enable drop and frame_sync while the request is pending
        do_reset();
        enable = 1'b1; frame_base = 32'h2000; frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (!req_valid || req_addr != 32'h2000) bad = 1'b1;
            tick();
        end
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (!req_valid || req_addr != 32'h2000) bad = 1'b1;
        end
        check("bp_hold_stable", 32'(bad), 32'd0);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("bp_overrun", 32'(overrun), 32'd1);
        check("bp_hold_after_sync", req_addr, 32'h2000);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("bp_idle_after_hs", 32'(req_valid), 32'd0);
        check("bp_hs_counted", 32'(dut.committed_q), 32'd16);
        repeat (3) tick();
        check("bp_stays_idle", 32'(req_valid), 32'd0);

        // Overrun with enable held: reload happens once the pending request is accepted
        do_reset();
        enable = 1'b1; frame_base = 32'h2000; frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        repeat (5) tick();
        frame_base = 32'h8000; frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0; frame_base = '0;
        check("ovr_flag", 32'(overrun), 32'd1);
        repeat (2) tick();
        check("ovr_hold_valid", 32'(req_valid), 32'd1);
        check("ovr_hold_addr", req_addr, 32'h2000);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("ovr_reload_valid", 32'(req_valid), 32'd1);
        check("ovr_reload_addr", req_addr, 32'h8000);
        check("ovr_committed", 32'(dut.committed_q), 32'd16);

        // Asynchronous reset mid-frame
        do_reset();
        enable = 1'b1; frame_base = 32'h4000; req_ready = 1'b1; frame_sync = 1'b1;
        fifo_rd = 1'b1;
        tick();
        frame_sync = 1'b0;
        repeat (3) tick();
        fifo_rd = 1'b0;
        #3;
        pixel_rst_n = 1'b0;
        #1;
        check("arst_req_valid", 32'(req_valid), 32'd0);
        check("arst_req_addr", req_addr, 32'd0);
        check("arst_underflow", 32'(underflow), 32'd0);
        check("arst_frame_done", 32'(frame_done), 32'd0);
        tick();
        pixel_rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (req_valid) bad = 1'b1;
        end
        check("arst_quiet_until_sync", 32'(bad), 32'd0);
        frame_base = 32'h5000; frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("arst_restart_valid", 32'(req_valid), 32'd1);
        check("arst_restart_addr", req_addr, 32'h5000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
